// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// TXDATA at BASE_ADDR queues a byte; STATUS at BASE_ADDR+4 reports
// {count, ovf, empty, full, busy}. Writing STATUS with bit 3 set clears ovf.
module uart_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0040,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Adr_in,
    input  logic        MemWrite_in,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        tx
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      count4;

    logic sel_data, sel_stat;
    logic push_req, push_ok, pop;
    logic full, empty, busy, baud_last;
    logic unused_data;

    assign sel_data  = (Adr_in == BASE_ADDR);
    assign sel_stat  = (Adr_in == BASE_ADDR + 32'd4);
    assign push_req  = MemWrite_in && sel_data;
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != StIdle);
    assign pop       = (state_q == StIdle) && !empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok   = push_req && (!full || pop);
    assign count_d   = count_q + CW'(push_ok) - CW'(pop);
    assign count4    = 4'(count_q);
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign tx        = tx_q;
    assign unused_data = ^Data_in[31:8];

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_comb begin
        ovf_d = ovf_q;
        if (MemWrite_in && sel_stat && Data_in[3]) ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;
    end

    // Bus read mux, combinational on the address.
    always_comb begin
        Data_out = 32'd0;
        if (sel_stat) Data_out = {24'd0, count4, ovf_q, empty, full, busy};
    end

    // Transmit FSM next state; tx_d is derived from the next state so tx is registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, FIFO pointers and flags; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr_q] <= Data_in[7:0];
    end

endmodule
